// File: rtl/mod_counter.sv
// Programmable-modulus up/down counter with optional enable prescaler,
// wrap/saturate boundary handling, terminal-count pulse and sticky wrap flag.
module mod_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             c,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             wrap_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped,
  output logic             at_bound
);

  logic             advance;
  logic             step;
  logic             wrap_ev;
  logic [WIDTH-1:0] load_clamped;

  assign advance      = en & ~clr & ~load;
  assign load_clamped = (load_val > limit) ? limit : load_val;
  assign at_bound     = up ? (count == limit) : (count == '0);

  generate
    if (PRESCALE > 1) begin : g_pre
      localparam int PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
      logic [PW-1:0] pre;

      // Any clr/load restarts the prescale period from zero.
      always_ff @(posedge c or posedge rst) begin
        if (rst) begin
          pre <= '0;
        end else if (clr || load) begin
          pre <= '0;
        end else if (en) begin
          if (pre == PRE_LAST) pre <= '0;
          else                 pre <= pre + PW'(1);
        end
      end

      assign step = advance & (pre == PRE_LAST);
    end else begin : g_nopre
      assign step = advance;
    end
  endgenerate

  // A wrap is decided against the compare, never by arithmetic overflow.
  always_comb begin
    wrap_ev = 1'b0;
    if (step && !sat_mode) begin
      if (up) wrap_ev = (count >= limit);
      else    wrap_ev = (count == '0);
    end
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (load) begin
        count <= load_clamped;
      end else if (step) begin
        if (up) begin
          if (count < limit)  count <= count + WIDTH'(1);
          else if (wrap_ev) begin
            count <= '0;
            tc    <= 1'b1;
          end else            count <= limit;
        end else begin
          if (count > limit)       count <= limit;
          else if (count != '0)    count <= count - WIDTH'(1);
          else if (wrap_ev) begin
            count <= limit;
            tc    <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst)           wrapped <= 1'b0;
    else if (wrap_ev)  wrapped <= 1'b1;
    else if (wrap_clr) wrapped <= 1'b0;
  end

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: one instance without prescaler, one with PRESCALE=3.
module tb_mod_counter;

  logic       c = 1'b0;
  logic       rst;
  logic       en, clr, load, up, sat_mode, wrap_clr;
  logic [3:0] load_val, limit;
  logic [3:0] count1, count3;
  logic       tc1, tc3, wrapped1, wrapped3, at_bound1, at_bound3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 c = ~c;

  mod_counter #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .c(c), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up(up), .sat_mode(sat_mode), .limit(limit), .wrap_clr(wrap_clr),
    .count(count1), .tc(tc1), .wrapped(wrapped1), .at_bound(at_bound1)
  );

  mod_counter #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .c(c), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up(up), .sat_mode(sat_mode), .limit(limit), .wrap_clr(wrap_clr),
    .count(count3), .tc(tc3), .wrapped(wrapped3), .at_bound(at_bound3)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge c);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 0; clr = 0; load = 0; up = 1; sat_mode = 0;
    wrap_clr = 0; load_val = 0; limit = 4'd9;
    #12;
    chk("reset_count", count1, 0);
    chk("reset_tc", tc1, 0);
    chk("reset_wrapped", wrapped1, 0);
    @(posedge c); #1;
    rst = 1'b0;

    // Count up with wrap at limit 9
    en = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("up_count_%0d", i), count1, i % 10);
      chk($sformatf("up_tc_%0d", i), tc1, (i == 10) ? 1 : 0);
      chk($sformatf("up_atb_%0d", i), at_bound1, (i == 9) ? 1 : 0);
    end
    chk("up_wrapped", wrapped1, 1);

    // Down with saturation
    en = 0; load = 1; load_val = 4'd2; wrap_clr = 1;
    tick();
    chk("load2_count", count1, 2);
    chk("load2_wrapped", wrapped1, 0);
    load = 0; wrap_clr = 0; up = 0; sat_mode = 1; en = 1;
    tick(); chk("dn_count_1", count1, 1); chk("dn_tc_1", tc1, 0);
    tick(); chk("dn_count_2", count1, 0); chk("dn_tc_2", tc1, 0);
    chk("dn_atb", at_bound1, 1);
    tick(); chk("dn_count_3", count1, 0); chk("dn_tc_3", tc1, 0);
    tick(); chk("dn_count_4", count1, 0); chk("dn_tc_4", tc1, 0);
    chk("dn_wrapped", wrapped1, 0);

    // Clear beats load; load clamps to limit
    en = 0; load = 1; clr = 1; load_val = 4'd15; load_val = 4'd15;
    tick(); chk("clr_over_load", count1, 0);
    clr = 0;
    tick(); chk("load_clamp", count1, 9);
    load = 0;

    // Prescale by 3
    clr = 1; tick(); clr = 0;
    chk("pre_clr", count3, 0);
    up = 1; sat_mode = 0; en = 1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("pre_count_%0d", i), count3, i / 3);
    end
    tick(); chk("pre_en_a", count3, 3);
    en = 0;
    tick(); chk("pre_hold_a", count3, 3);
    tick(); chk("pre_hold_b", count3, 3);
    en = 1;
    tick(); chk("pre_en_b", count3, 3);
    tick(); chk("pre_delayed_step", count3, 4);
    chk("pre_dut1_wrapped", wrapped1, 1);

    // Asynchronous reset mid-cycle, mid-prescale
    en = 0; load = 1; load_val = 4'd6;
    tick(); load = 0; en = 1;
    tick();
    chk("ar_pre_count", count1, 7);
    #3 rst = 1'b1;
    #1;
    chk("ar_count", count1, 0);
    chk("ar_wrapped", wrapped1, 0);
    chk("ar_count3", count3, 0);
    rst = 1'b0;
    tick(); chk("ar_rel_1", count1, 1);
    tick(); chk("ar_rel_2", count1, 2); chk("ar_pre_discard", count3, 0);
    tick(); chk("ar_pre_step", count3, 1);

    // limit = 0 in wrap mode: every step wraps
    limit = 4'd0; clr = 1; tick(); clr = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("lim0_count_%0d", i), count1, 0);
      chk($sformatf("lim0_tc_%0d", i), tc1, 1);
    end

    // Limit lowered below count while counting down
    limit = 4'd9; en = 0; load = 1; load_val = 4'd7;
    tick(); load = 0;
    limit = 4'd3; up = 0; en = 1;
    tick(); chk("lower_lim", count1, 3); chk("lower_lim_tc", tc1, 0);
    tick(); chk("lower_lim_next", count1, 2);

    // Saturate up at limit
    up = 1; sat_mode = 1; load = 1; load_val = 4'd3; tick(); load = 0;
    tick(); chk("sat_up_count", count1, 3); chk("sat_up_tc", tc1, 0);

    // Wrap coinciding with wrap_clr keeps the flag set
    sat_mode = 0; en = 0; wrap_clr = 1;
    tick(); chk("wclr", wrapped1, 0);
    wrap_clr = 0; up = 0; en = 1; load = 1; load_val = 4'd0; tick(); load = 0;
    wrap_clr = 1;
    tick();
    chk("wrap_vs_clr_count", count1, 3);
    chk("wrap_vs_clr_tc", tc1, 1);
    chk("wrap_vs_clr_flag", wrapped1, 1);
    wrap_clr = 0; en = 0;
    tick(); chk("tc_one_cycle", tc1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
